i2c_pad_filter: RTL and testbench
=================================

I2C_PAD_FILTER -- requirements
Module: i2c_pad_filter

Interface
REQ-001 SHALL have parameter FILT_DEPTH, default 4: consecutive equal samples needed to accept a level change; legal range 1..15.
REQ-002 SHALL have parameter BUS_FREE_CYC, default 64: both-lines-high cycles in BUSY that force bus free; legal range 1..65535.
REQ-003 SHALL have port wb_clk_i  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port wb_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports scl_pad_i, sda_pad_i  in  1 each  raw, asynchronous open-drain pad inputs.
REQ-006 SHALL have ports scl_oe_i, scl_o_i, sda_oe_i, sda_o_i  in  1 each  drive requests from the I2C core.
REQ-007 SHALL have ports scl_pad_oe_o, sda_pad_oe_o  out  1 each  pad pull-low enables; pad output value is tied 0 externally.
REQ-008 SHALL have ports scl_f_o, sda_f_o  out  1 each  filtered levels; these feed the core scl_in/sda_in.
REQ-009 SHALL have ports scl_rise_o, scl_fall_o, start_o, stop_o  out  1 each  single-cycle event pulses.
REQ-010 SHALL have port bus_busy_o  out  1  high between START and STOP or bus-free timeout.
REQ-011 SHALL have port glitch_cnt_o  out  8  count of rejected spikes, saturating.
REQ-012 SHALL have port glitch_clr_i  in  1  synchronous clear of glitch_cnt_o.

Function
REQ-013 SHALL compute scl_pad_oe_o = scl_oe_i & ~scl_o_i and sda_pad_oe_o = sda_oe_i & ~sda_o_i combinationally, with no dependency on reset.
REQ-014 SHALL pass each pad through a 2-flop synchronizer.
REQ-015 SHALL keep one 4-bit mismatch counter per line, defined as follows:
- Increment when the synchronized value differs from the filtered value.
- Clear when they match.
- Toggle the filtered value and clear the counter on the cycle the count reaches FILT_DEPTH.
REQ-016 SHALL give filtered-output latency of FILT_DEPTH+2 rising edges after a pad change, counting the first sampling edge as edge 1.
REQ-017 SHALL increment glitch_cnt_o by 1 per line whenever a nonzero mismatch counter clears without toggling.
- Both lines glitching in the same cycle SHALL add 2.
- glitch_cnt_o SHALL saturate at 255.
REQ-018 SHALL clear glitch_cnt_o to 0 when glitch_clr_i is high, with priority over any simultaneous increment.
REQ-019 SHALL register previous filtered values and assert scl_rise_o/scl_fall_o for exactly one cycle, on the edge after scl_f_o changes.
REQ-020 SHALL detect START when sda_f falls while scl_f is 1 in both the previous and current cycle, and pulse start_o for one cycle, on the edge after the sda_f change.
REQ-021 SHALL detect STOP when sda_f rises under the same SCL condition, and pulse stop_o for one cycle, on the edge after the sda_f change.
REQ-022 SHALL report neither START nor STOP when scl_f and sda_f change on the same edge.
REQ-023 SHALL implement a 2-state FSM, IDLE and BUSY, with bus_busy_o = (state==BUSY), registered:
- IDLE->BUSY on START.
- BUSY->IDLE on STOP.
- BUSY->BUSY on repeated START (start_o still pulses).
REQ-024 SHALL, in BUSY, keep a 16-bit free counter that increments while scl_f=sda_f=1 and clears otherwise or on START; on reaching BUS_FREE_CYC it SHALL go to IDLE and clear.
REQ-025 SHALL hold the free counter at 0 in IDLE.
REQ-026 SHALL, on a STOP and a timeout in the same cycle, go to IDLE once, with stop_o pulsed.

Reset
REQ-027 SHALL, while wb_rst_n_i=0, immediately force the following:
- Synchronizer flops, filtered values and previous-value registers = 1.
- Mismatch and free counters = 0.
- glitch_cnt_o = 0, FSM = IDLE, all pulses = 0.
REQ-028 SHALL, on reset assertion mid-BUSY, drop bus_busy_o asynchronously with no stop_o.
REQ-029 SHALL, after reset release with pads high, produce no event pulses.

Verification
REQ-030 SHALL cover: pads=1, rst_n pulsed low for 3 cycles then released -> scl_f_o=sda_f_o=1, bus_busy_o=0, glitch_cnt_o=0, no pulses for 20 cycles.
REQ-031 SHALL cover: FILT_DEPTH=4, SCL held 1, sda_pad 1->0 -> sda_f_o falls at edge 6, start_o high only at edge 7, bus_busy_o=1 from edge 7.
REQ-032 SHALL cover: SCL=1, sda_pad low for 2 cycles only -> sda_f_o stays 1, no start_o, glitch_cnt_o 0->1.
REQ-033 SHALL cover: after START, SCL low, SDA to 1, SCL to 1, both held 64 cycles, BUS_FREE_CYC=64 -> no stop_o, bus_busy_o=0 after the 64th both-high filtered cycle.
REQ-034 SHALL cover: glitch_cnt_o=255 plus another spike -> stays 255; spike coincident with glitch_clr_i -> 0.
REQ-035 SHALL cover: START then SDA rise with SCL high -> stop_o single pulse, bus_busy_o=0; a simultaneous SCL+SDA change -> neither pulse.

Source files
------------

// File: rtl/i2c_pad_filter.sv
// I2C pad conditioning: sync + glitch filter on SCL/SDA, START/STOP/edge events, bus-busy tracking.
// Latency: filtered level FILT_DEPTH+2 edges after a pad change; event pulses one edge later.
// Backpressure: none; pad enables are purely combinational, all other outputs free-running.
module i2c_pad_filter #(
    parameter int FILT_DEPTH   = 4,
    parameter int BUS_FREE_CYC = 64
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    input  logic       scl_oe_i,
    input  logic       scl_o_i,
    input  logic       sda_oe_i,
    input  logic       sda_o_i,
    input  logic       glitch_clr_i,
    output logic       scl_pad_oe_o,
    output logic       sda_pad_oe_o,
    output logic       scl_f_o,
    output logic       sda_f_o,
    output logic       scl_rise_o,
    output logic       scl_fall_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       bus_busy_o,
    output logic [7:0] glitch_cnt_o
);

    // Counter value on which the next mismatching sample flips the filter.
    localparam logic [3:0]  FILT_LAST = 4'(FILT_DEPTH - 1);
    // Free-counter value on which the next both-high cycle declares the bus free.
    localparam logic [15:0] FREE_LAST = 16'(BUS_FREE_CYC - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [1:0]  scl_sync;
    logic [1:0]  sda_sync;
    logic [3:0]  scl_cnt;
    logic [3:0]  sda_cnt;
    logic        scl_filt;
    logic        sda_filt;
    logic        scl_prev;
    logic        sda_prev;
    logic        scl_glitch;
    logic        sda_glitch;
    logic        start_det;
    logic        stop_det;
    logic [1:0]  glitch_inc;
    logic [8:0]  glitch_sum;
    logic [15:0] free_cnt;
    state_t      state;

    // Pads are open-drain: only a request to drive 0 enables the pull-down.
    assign scl_pad_oe_o = scl_oe_i & ~scl_o_i;
    assign sda_pad_oe_o = sda_oe_i & ~sda_o_i;

    assign scl_f_o    = scl_filt;
    assign sda_f_o    = sda_filt;
    assign bus_busy_o = (state == BUSY);

    // A spike is a mismatch run that ends before it could flip the filter.
    assign scl_glitch = (scl_sync[1] == scl_filt) && (scl_cnt != 4'd0);
    assign sda_glitch = (sda_sync[1] == sda_filt) && (sda_cnt != 4'd0);

    // SCL must be high and stable across both cycles, so a simultaneous SCL change masks the event.
    assign start_det = scl_prev & scl_filt & sda_prev & ~sda_filt;
    assign stop_det  = scl_prev & scl_filt & ~sda_prev & sda_filt;

    assign glitch_inc = {1'b0, scl_glitch} + {1'b0, sda_glitch};
    assign glitch_sum = {1'b0, glitch_cnt_o} + {7'd0, glitch_inc};

    // Two-flop synchronizers; idle-high reset matches a released open-drain bus.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_pad_i};
            sda_sync <= {sda_sync[0], sda_pad_i};
        end
    end

    // SCL filter: flip only after FILT_DEPTH consecutive differing samples.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            scl_filt <= 1'b1;
            scl_cnt  <= 4'd0;
        end else if (scl_sync[1] != scl_filt) begin
            if (scl_cnt == FILT_LAST) begin
                scl_filt <= ~scl_filt;
                scl_cnt  <= 4'd0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
        end else begin
            scl_cnt <= 4'd0;
        end
    end

    // SDA filter: same rule as SCL.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sda_filt <= 1'b1;
            sda_cnt  <= 4'd0;
        end else if (sda_sync[1] != sda_filt) begin
            if (sda_cnt == FILT_LAST) begin
                sda_filt <= ~sda_filt;
                sda_cnt  <= 4'd0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end else begin
            sda_cnt <= 4'd0;
        end
    end

    // Previous filtered levels and registered single-cycle event pulses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            scl_prev   <= 1'b1;
            sda_prev   <= 1'b1;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            scl_prev   <= scl_filt;
            sda_prev   <= sda_filt;
            scl_rise_o <= scl_filt & ~scl_prev;
            scl_fall_o <= ~scl_filt & scl_prev;
            start_o    <= start_det;
            stop_o     <= stop_det;
        end
    end

    // Saturating spike counter; a clear wins over any increment in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            glitch_cnt_o <= 8'd0;
        end else if (glitch_clr_i) begin
            glitch_cnt_o <= 8'd0;
        end else if (glitch_sum[8]) begin
            glitch_cnt_o <= 8'hff;
        end else begin
            glitch_cnt_o <= glitch_sum[7:0];
        end
    end

    // Bus state: START claims the bus, STOP or a long both-high idle releases it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= IDLE;
            free_cnt <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    free_cnt <= 16'd0;
                    if (start_det) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (stop_det) begin
                        state    <= IDLE;
                        free_cnt <= 16'd0;
                    end else if (start_det || !(scl_filt && sda_filt)) begin
                        free_cnt <= 16'd0;
                    end else if (free_cnt == FREE_LAST) begin
                        state    <= IDLE;
                        free_cnt <= 16'd0;
                    end else begin
                        free_cnt <= free_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    free_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_pad_filter.sv
// Bench for i2c_pad_filter: directed pad waveforms, a cycle model of the filter/event rules,
// and literal edge-by-edge expectations for the key scenarios.
// Inputs change 2 time units after a rising edge; outputs are compared on the falling edge.
module tb_i2c_pad_filter;

    localparam int FD = 4;
    localparam int BF = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scl_pad = 1'b1;
    logic       sda_pad = 1'b1;
    logic       scl_oe = 1'b0;
    logic       scl_o = 1'b0;
    logic       sda_oe = 1'b0;
    logic       sda_o = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       scl_pad_oe;
    logic       sda_pad_oe;
    logic       scl_f;
    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;
    logic       busy;
    logic [7:0] glitch_cnt;

    int tests = 0;
    int fails = 0;
    int start_seen = 0;
    int stop_seen = 0;

    always #5 clk = ~clk;

    i2c_pad_filter #(.FILT_DEPTH(FD), .BUS_FREE_CYC(BF)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .scl_pad_i    (scl_pad),
        .sda_pad_i    (sda_pad),
        .scl_oe_i     (scl_oe),
        .scl_o_i      (scl_o),
        .sda_oe_i     (sda_oe),
        .sda_o_i      (sda_o),
        .glitch_clr_i (glitch_clr),
        .scl_pad_oe_o (scl_pad_oe),
        .sda_pad_oe_o (sda_pad_oe),
        .scl_f_o      (scl_f),
        .sda_f_o      (sda_f),
        .scl_rise_o   (scl_rise),
        .scl_fall_o   (scl_fall),
        .start_o      (start),
        .stop_o       (stop),
        .bus_busy_o   (busy),
        .glitch_cnt_o (glitch_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- reference model (index 0 = SCL, 1 = SDA) ----------------
    // Each line: pad seen through a 2-deep delay line; filtered level flips after FD
    // consecutive delayed samples that disagree with it; a shorter disagreeing run is a spike.
    bit m_dly [2][2];
    bit m_f   [2];
    bit m_fp  [2];
    bit m_nf  [2];
    bit m_pad [2];
    int m_run [2];
    bit m_rise, m_fall, m_start, m_stop, m_busy;
    int m_free, m_glitch, m_inc;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dly[i][0] = 1'b1; m_dly[i][1] = 1'b1;
            m_f[i] = 1'b1; m_fp[i] = 1'b1; m_run[i] = 0;
        end
        m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0; m_busy = 0;
        m_free = 0; m_glitch = 0;
    endtask

    task automatic model_step();
        m_pad[0] = scl_pad;
        m_pad[1] = sda_pad;
        m_inc = 0;
        for (int i = 0; i < 2; i++) begin
            m_nf[i] = m_f[i];
            if (m_dly[i][1] != m_f[i]) begin
                m_run[i]++;
                if (m_run[i] == FD) begin
                    m_nf[i] = ~m_f[i];
                    m_run[i] = 0;
                end
            end else begin
                if (m_run[i] > 0) m_inc++;
                m_run[i] = 0;
            end
            m_dly[i][1] = m_dly[i][0];
            m_dly[i][0] = m_pad[i];
        end
        // events are judged from the filtered history of the two previous cycles
        m_rise  = m_f[0] & ~m_fp[0];
        m_fall  = ~m_f[0] & m_fp[0];
        m_start = m_f[0] & m_fp[0] & m_fp[1] & ~m_f[1];
        m_stop  = m_f[0] & m_fp[0] & ~m_fp[1] & m_f[1];
        if (!m_busy) begin
            m_free = 0;
            if (m_start) m_busy = 1;
        end else if (m_stop) begin
            m_busy = 0;
            m_free = 0;
        end else if (m_f[0] && m_f[1]) begin
            m_free++;
            if (m_free == BF) begin
                m_busy = 0;
                m_free = 0;
            end
        end else begin
            m_free = 0;
        end
        if (glitch_clr) m_glitch = 0;
        else m_glitch = (m_glitch + m_inc > 255) ? 255 : m_glitch + m_inc;
        for (int i = 0; i < 2; i++) begin
            m_fp[i] = m_f[i];
            m_f[i]  = m_nf[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    logic [31:0] act_vec, exp_vec;
    initial begin
        forever begin
            @(negedge clk);
            if (start) start_seen++;
            if (stop) stop_seen++;
            act_vec = {15'd0, scl_pad_oe, sda_pad_oe, scl_f, sda_f, scl_rise, scl_fall,
                       start, stop, busy, glitch_cnt};
            exp_vec = {15'd0, scl_oe & ~scl_o, sda_oe & ~sda_o, m_f[0], m_f[1], m_rise, m_fall,
                       m_start, m_stop, m_busy, 8'(m_glitch)};
            check("cycle_model", act_vec, exp_vec);
        end
    end

    // ---------------- directed scenarios ----------------
    int st0, sp0;
    logic [3:0] combo;
    initial begin
        // reset pulse of three cycles with pads high
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_scl_f", scl_f, 1);
        check("rst_sda_f", sda_f, 1);
        check("rst_busy", busy, 0);
        check("rst_glitch", glitch_cnt, 0);
        for (int e = 0; e < 20; e++) begin
            tick(1);
            check("rst_no_pulse", {scl_rise, scl_fall, start, stop}, 0);
        end

        // pad enables: pull low only for an enabled drive of 0
        for (int k = 0; k < 16; k++) begin
            combo = 4'(k);
            {scl_oe, scl_o, sda_oe, sda_o} = combo;
            #1;
            check("scl_pad_oe", scl_pad_oe, combo[3] & ~combo[2]);
            check("sda_pad_oe", sda_pad_oe, combo[1] & ~combo[0]);
        end
        {scl_oe, scl_o, sda_oe, sda_o} = 4'b0000;
        tick(1);

        // SDA low for two samples only: rejected spike
        sda_pad = 1'b0;
        tick(2);
        sda_pad = 1'b1;
        for (int e = 3; e <= 8; e++) begin
            tick(1);
            check("spike_sda_f", sda_f, 1);
            check("spike_no_start", start, 0);
        end
        check("spike_glitch_1", glitch_cnt, 1);

        // START: sda_f falls on edge 6, start_o only on edge 7, busy from edge 7
        sda_pad = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            check("start_sda_f", sda_f, (e >= 6) ? 0 : 1);
            check("start_pulse", start, (e == 7) ? 1 : 0);
            check("start_busy", busy, (e >= 7) ? 1 : 0);
        end

        // bus-free timeout: SCL low, SDA high, SCL high, then 64 both-high cycles
        sp0 = stop_seen;
        scl_pad = 1'b0;
        tick(8);
        sda_pad = 1'b1;
        tick(8);
        scl_pad = 1'b1;
        for (int e = 1; e <= 72; e++) begin
            tick(1);
            if (e == 6) check("timeout_scl_up", scl_f, 1);
            if (e == 69) check("timeout_busy_before", busy, 1);
            if (e == 70) check("timeout_busy_after", busy, 0);
        end
        check("timeout_no_stop", stop_seen - sp0, 0);

        // START then STOP with SCL high
        sda_pad = 1'b0;
        tick(10);
        check("stop_pre_busy", busy, 1);
        sda_pad = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick(1);
            check("stop_pulse", stop, (e == 7) ? 1 : 0);
            check("stop_busy", busy, (e < 7) ? 1 : 0);
        end

        // simultaneous SCL+SDA changes must not register START or STOP
        sda_pad = 1'b0;
        tick(10);
        check("simul_pre_busy", busy, 1);
        st0 = start_seen;
        sp0 = stop_seen;
        scl_pad = 1'b0;
        sda_pad = 1'b1;
        tick(10);
        check("simul_levels_a", {scl_f, sda_f}, 2'b01);
        scl_pad = 1'b1;
        sda_pad = 1'b0;
        tick(10);
        check("simul_levels_b", {scl_f, sda_f}, 2'b10);
        check("simul_no_start", start_seen - st0, 0);
        check("simul_no_stop", stop_seen - sp0, 0);
        check("simul_busy", busy, 1);
        sda_pad = 1'b1;
        tick(10);
        check("simul_end_idle", busy, 0);

        // saturation: 254 more spikes take the count from 1 to 255, one more holds it
        for (int s = 0; s < 255; s++) begin
            sda_pad = 1'b0;
            tick(2);
            sda_pad = 1'b1;
            tick(4);
            if (s == 253) check("glitch_255", glitch_cnt, 255);
        end
        check("glitch_sat", glitch_cnt, 255);

        // spike whose increment lands on the same edge as glitch_clr
        sda_pad = 1'b0;
        tick(2);
        sda_pad = 1'b1;
        tick(2);
        check("clr_pre", glitch_cnt, 255);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("clr_wins", glitch_cnt, 0);
        tick(3);
        check("clr_hold", glitch_cnt, 0);

        // reset asserted mid-BUSY drops busy immediately, without STOP
        sda_pad = 1'b0;
        tick(10);
        check("rstbusy_pre", busy, 1);
        scl_oe = 1'b1;
        scl_o  = 1'b0;
        sp0 = stop_seen;
        rst_n = 1'b0;
        #1;
        check("rstbusy_busy", busy, 0);
        check("rstbusy_stop", stop, 0);
        check("rstbusy_oe", scl_pad_oe, 1);
        check("rstbusy_sda_f", sda_f, 1);
        sda_pad = 1'b1;
        scl_oe = 1'b0;
        tick(2);
        rst_n = 1'b1;
        st0 = start_seen;
        tick(20);
        check("rel_no_start", start_seen - st0, 0);
        check("rel_no_stop", stop_seen - sp0, 0);
        check("rel_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
